// File: rtl/powerline_residual_meter_pkg.sv
// Shared types and constants for the powerline residual meter: FSM states,
// default parameters and the saturating-magnitude ceiling.
package powerline_residual_pkg;

  typedef enum logic [0:0] {
    WARMUP = 1'b0,
    ACCUM  = 1'b1
  } meter_state_e;

  localparam int DEF_WL       = 28;
  localparam int DEF_FRAC     = 12;
  localparam int DEF_LOG2_WIN = 8;
  localparam int DEF_SETTLE   = 64;
  localparam int DEF_CONSEC   = 3;

  // Largest magnitude representable in WL-1 unsigned bits: 2^(WL-1)-1.
  function automatic logic [63:0] sat_max(input int wl);
    return (64'd1 << (wl - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/powerline_residual_meter_if.sv
// Sample/threshold inputs and level/peak/alarm outputs of the residual meter.
interface powerline_residual_meter_if
  import powerline_residual_pkg::*;
#(
  parameter int WL = DEF_WL
);
  logic signed [WL-1:0] y_in;
  logic                 y_valid;
  logic        [WL-2:0] thresh;
  logic        [WL-2:0] level;
  logic                 level_valid;
  logic        [WL-2:0] peak;
  logic                 alarm;
  logic                 settling;

  modport master (
    output y_in, y_valid, thresh,
    input  level, level_valid, peak, alarm, settling
  );

  modport slave (
    input  y_in, y_valid, thresh,
    output level, level_valid, peak, alarm, settling
  );
endinterface

// File: rtl/powerline_residual_meter_residual_abs_sat.sv
// Combinational saturating absolute value: signed WL bits in, unsigned WL-1 out.
// The most negative input clamps to 2^(WL-1)-1 instead of wrapping.
module residual_abs_sat
  import powerline_residual_pkg::*;
#(
  parameter int WL = DEF_WL
) (
  input  logic signed [WL-1:0] y_i,
  output logic        [WL-2:0] mag_o
);
  localparam logic [WL-2:0] SAT = (WL-1)'(sat_max(WL));
  localparam logic [WL-2:0] ONE = (WL-1)'(1);

  // Two's-complement negate on the low bits; only -2^(WL-1) has them all zero.
  always_comb begin
    mag_o = y_i[WL-2:0];
    if (y_i[WL-1]) begin
      if (y_i[WL-2:0] == '0) begin
        mag_o = SAT;
      end else begin
        mag_o = (~y_i[WL-2:0]) + ONE;
      end
    end else begin
      mag_o = y_i[WL-2:0];
    end
  end
endmodule

// File: rtl/powerline_residual_meter.sv
// Residual mains-hum meter: windowed mean |y| after a settle period, with a
// consecutive-window alarm. Peak hold is built when POWERLINE_RESIDUAL_PEAK_EN is defined.
module powerline_residual_meter
  import powerline_residual_pkg::*;
#(
  parameter int WL       = DEF_WL,
  parameter int FRAC     = DEF_FRAC,
  parameter int LOG2_WIN = DEF_LOG2_WIN,
  parameter int SETTLE   = DEF_SETTLE,
  parameter int CONSEC   = DEF_CONSEC
) (
  input  logic                      clk,
  input  logic                      reset,
  powerline_residual_meter_if.slave bus
);
  localparam int ACCW = WL - 1 + LOG2_WIN;
  localparam int WCW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int OCW  = $clog2(CONSEC + 1);
  localparam logic [LOG2_WIN-1:0] CNT_LAST  = '1;
  localparam logic [OCW-1:0]      OVER_MAX  = OCW'(CONSEC);
  localparam meter_state_e        RST_STATE = (SETTLE == 0) ? ACCUM : WARMUP;

  if (CONSEC < 1) begin : g_bad_consec
    $error("CONSEC must be at least 1");
  end
  if (FRAC < 0 || FRAC >= WL) begin : g_bad_frac
    $error("FRAC must lie within the word length");
  end

  meter_state_e         state_q, state_d;
  logic [WCW-1:0]       warm_q, warm_d;
  logic [ACCW-1:0]      acc_q, acc_d;
  logic [LOG2_WIN-1:0]  cnt_q, cnt_d;
  logic [OCW-1:0]       over_q, over_d;
  logic [WL-2:0]        level_q, level_d;
  logic                 lvalid_q, lvalid_d;
  logic                 alarm_q, alarm_d;

  logic [WL-2:0]        mag_s;
  logic [ACCW-1:0]      acc_sum_s;
  logic [WL-2:0]        level_new_s;
  logic [OCW-1:0]       over_inc_s;

  residual_abs_sat #(.WL(WL)) u_abs (
    .y_i   (bus.y_in),
    .mag_o (mag_s)
  );

  // Next-state for the settle/accumulate FSM, window close and alarm.
  always_comb begin
    state_d     = state_q;
    warm_d      = warm_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    over_d      = over_q;
    level_d     = level_q;
    lvalid_d    = 1'b0;
    alarm_d     = alarm_q;
    acc_sum_s   = acc_q + ACCW'(mag_s);
    level_new_s = acc_sum_s[ACCW-1:LOG2_WIN];
    if (over_q == OVER_MAX) begin
      over_inc_s = over_q;
    end else begin
      over_inc_s = over_q + OCW'(1);
    end

    case (state_q)
      WARMUP: begin
        if (bus.y_valid) begin
          if (int'(warm_q) >= SETTLE - 1) begin
            state_d = ACCUM;
            warm_d  = '0;
          end else begin
            warm_d = warm_q + WCW'(1);
          end
        end else begin
          state_d = state_q;
        end
      end
      ACCUM: begin
        if (bus.y_valid) begin
          if (cnt_q == CNT_LAST) begin
            level_d  = level_new_s;
            lvalid_d = 1'b1;
            acc_d    = '0;
            cnt_d    = '0;
            // Strictly greater: a level equal to the threshold resets the run.
            if (level_new_s > bus.thresh) begin
              over_d  = over_inc_s;
              alarm_d = (over_inc_s == OVER_MAX);
            end else begin
              over_d  = '0;
              alarm_d = 1'b0;
            end
          end else begin
            acc_d = acc_sum_s;
            cnt_d = cnt_q + LOG2_WIN'(1);
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = RST_STATE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RST_STATE;
      warm_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      over_q   <= '0;
      level_q  <= '0;
      lvalid_q <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      warm_q   <= warm_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      over_q   <= over_d;
      level_q  <= level_d;
      lvalid_q <= lvalid_d;
      alarm_q  <= alarm_d;
    end
  end

`ifdef POWERLINE_RESIDUAL_PEAK_EN
  logic [WL-2:0] run_max_q, run_max_d;
  logic [WL-2:0] peak_q, peak_d;
  logic [WL-2:0] max_s;

  // Running max over the window; the closing sample is folded in directly.
  always_comb begin
    run_max_d = run_max_q;
    peak_d    = peak_q;
    if (mag_s > run_max_q) begin
      max_s = mag_s;
    end else begin
      max_s = run_max_q;
    end
    if (state_q == ACCUM && bus.y_valid) begin
      if (cnt_q == CNT_LAST) begin
        peak_d    = max_s;
        run_max_d = '0;
      end else begin
        run_max_d = max_s;
      end
    end else begin
      run_max_d = run_max_q;
    end
  end

  // Peak registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_max_q <= '0;
      peak_q    <= '0;
    end else begin
      run_max_q <= run_max_d;
      peak_q    <= peak_d;
    end
  end

  assign bus.peak = peak_q;
`else
  assign bus.peak = '0;
`endif

  assign bus.level       = level_q;
  assign bus.level_valid = lvalid_q;
  assign bus.alarm       = alarm_q;
  assign bus.settling    = (state_q == WARMUP);
endmodule

// File: tb/tb_powerline_residual_meter.sv
// Directed bench for powerline_residual_meter (LOG2_WIN=4, SETTLE=2, CONSEC=2);
// peak expectations follow POWERLINE_RESIDUAL_PEAK_EN.
module tb_powerline_residual_meter;
  localparam int WL = 28;
`ifdef POWERLINE_RESIDUAL_PEAK_EN
  localparam bit PEAK_ON = 1'b1;
`else
  localparam bit PEAK_ON = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   cyc;
  int   first_cyc;
  int   last_cyc;
  bit   lv_now;
  bit   early;

  powerline_residual_meter_if #(.WL(WL)) bus ();

  powerline_residual_meter #(
    .WL(WL), .FRAC(12), .LOG2_WIN(4), .SETTLE(2), .CONSEC(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One valid sample; optionally followed by one idle cycle.
  task automatic send_sample(input logic signed [WL-1:0] v, input bit gap);
    @(negedge clk);
    bus.y_in    = v;
    bus.y_valid = 1'b1;
    @(posedge clk);
    #1;
    lv_now   = bus.level_valid;
    last_cyc = cyc;
    if (gap) begin
      @(negedge clk);
      bus.y_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.y_valid = 1'b0;
  endtask

  task automatic run_window(input string tag, input logic signed [WL-1:0] a,
                            input logic signed [WL-1:0] b, input bit gap);
    early = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send_sample(i[0] ? b : a, gap);
      if (i == 0) first_cyc = last_cyc;
      if (i < 15 && lv_now) early = 1'b1;
    end
    check_eq({tag, "_early_lv"}, early, 0);
    check_eq({tag, "_lv"}, lv_now, 1);
    go_idle();
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    cyc         = 0;
    reset       = 1'b0;
    bus.y_in    = '0;
    bus.y_valid = 1'b0;
    bus.thresh  = 27'h7FF_FFFF;
    #12;
    check_eq("rst_level", bus.level, 0);
    check_eq("rst_lv", bus.level_valid, 0);
    check_eq("rst_peak", bus.peak, 0);
    check_eq("rst_alarm", bus.alarm, 0);
    check_eq("rst_settling", bus.settling, 1);
    @(negedge clk);
    reset = 1'b1;

    // Settle then two back-to-back windows of constant 1000.
    for (int i = 1; i <= 34; i++) begin
      send_sample(28'sd1000, 1'b0);
      check_eq("t1_lv", lv_now, (i == 18 || i == 34) ? 1 : 0);
      if (i == 1) check_eq("t1_settling_hi", bus.settling, 1);
      if (i == 2) check_eq("t1_settling_lo", bus.settling, 0);
      if (i == 18) check_eq("t1_level", bus.level, 1000);
    end
    go_idle();
    repeat (3) @(posedge clk);
    #1;
    check_eq("t1_idle_lv", bus.level_valid, 0);
    check_eq("t1_hold_level", bus.level, 1000);

    run_window("alt", 28'sd3192516, -28'sd3192516, 1'b0);
    check_eq("alt_level", bus.level, 3192516);
    check_eq("alt_peak", bus.peak, PEAK_ON ? 3192516 : 0);

    run_window("neg", 28'sh800_0000, 28'sh800_0000, 1'b0);
    check_eq("neg_level", bus.level, 134217727);
    check_eq("neg_peak", bus.peak, PEAK_ON ? 134217727 : 0);
    check_eq("neg_alarm_eq_thresh", bus.alarm, 0);

    run_window("gap", 28'sd1000, 28'sd1000, 1'b1);
    check_eq("gap_level", bus.level, 1000);
    check_eq("gap_span", last_cyc - first_cyc, 30);
    check_eq("gap_peak", bus.peak, PEAK_ON ? 1000 : 0);

    bus.thresh = 27'd500;
    run_window("a1", 28'sd1000, 28'sd1000, 1'b0);
    check_eq("a1_alarm", bus.alarm, 0);
    run_window("a2", 28'sd1000, 28'sd1000, 1'b0);
    check_eq("a2_alarm", bus.alarm, 1);
    repeat (4) @(posedge clk);
    #1;
    check_eq("a2_alarm_hold", bus.alarm, 1);
    run_window("a3", 28'sd500, 28'sd500, 1'b0);
    check_eq("a3_level", bus.level, 500);
    check_eq("a3_alarm", bus.alarm, 0);
    run_window("a4", 28'sd1000, 28'sd1000, 1'b0);
    check_eq("a4_alarm", bus.alarm, 0);
    run_window("a5", 28'sd1000, 28'sd1000, 1'b0);
    check_eq("a5_alarm", bus.alarm, 1);

    // Reset in the middle of a window.
    for (int i = 0; i < 10; i++) send_sample(28'sd2000, 1'b0);
    go_idle();
    #2;
    reset = 1'b0;
    #1;
    check_eq("mid_rst_level", bus.level, 0);
    check_eq("mid_rst_lv", bus.level_valid, 0);
    check_eq("mid_rst_peak", bus.peak, 0);
    check_eq("mid_rst_alarm", bus.alarm, 0);
    check_eq("mid_rst_settling", bus.settling, 1);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      send_sample(28'sd1000, 1'b0);
      check_eq("post_rst_lv", lv_now, (i == 18) ? 1 : 0);
      if (i == 1) check_eq("post_rst_settling", bus.settling, 1);
    end
    go_idle();
    check_eq("post_rst_level", bus.level, 1000);
    check_eq("post_rst_alarm", bus.alarm, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/powerline_residual_meter.md
Name: powerline_residual_meter

Overview:
- Sits directly downstream of the 6th-order Chebyshev band-stop IIR (60 Hz notch, 360 Hz sample rate).
- Consumes the filter output y, which is signed Q16.12 with WL=28.
- Measures residual mains-hum level as the mean absolute value over a fixed window of valid samples, with optional peak hold.
- Raises an alarm when the notch leaves more residual than a programmable threshold for consecutive windows.

Parameters:
- WL, 28, sample word length (Q(WL-FRAC).FRAC, two's complement).
- FRAC, 12, fractional bits; informational only, no arithmetic depends on it.
- LOG2_WIN, 8, window = 2^LOG2_WIN valid samples; the mean is a right shift.
- SETTLE, 64, valid samples discarded after reset to skip the filter transient; 0 allowed.
- CONSEC, 3, consecutive over-threshold windows needed to assert alarm; at least 1.

Ports:
- clk, in, 1, system clock (rising edge).
- reset, in, 1, asynchronous active-low reset; reset=0 clears all state.
- y_in, in, WL, signed filter output sample.
- y_valid, in, 1, y_in is qualified this cycle; may have arbitrary gaps.
- thresh, in, WL-1, unsigned level threshold (same LSB weight as y_in); sampled at window end.
- level, out, WL-1, unsigned mean-absolute level of the last complete window.
- level_valid, out, 1, one-cycle pulse when level updates.
- peak, out, WL-1, largest |y_in| in the last complete window (see Optional Feature).
- alarm, out, 1, residual-too-high flag.
- settling, out, 1, high while in WARMUP.

Behaviour:
- Reset values: level=0, level_valid=0, peak=0, alarm=0, settling=1. Accumulator, sample counter and over-threshold counter are 0. State is WARMUP, or ACCUM if SETTLE=0.
- Magnitude: |y_in|, saturating. The most negative input -2^(WL-1) maps to 2^(WL-1)-1. The result is WL-1 bits unsigned.
- Accumulator width is WL-1+LOG2_WIN bits; it can never overflow.
- Only cycles with y_valid=1 count; idle cycles change nothing.
- FSM state WARMUP: count valid samples; on the SETTLE-th one go to ACCUM with settling=0. Samples taken in WARMUP are not accumulated.
- FSM state ACCUM: acc += |y_in| and cnt++ on each valid sample.
- On the 2^LOG2_WIN-th valid sample, at the same clock edge:
  - level <= (acc + |y_in|) >> LOG2_WIN
  - level_valid <= 1 for exactly one cycle
  - acc <= 0, cnt <= 0
- The window closes with no gap: the next valid sample starts a fresh window. Latency is one clock from the edge accepting the last sample to level_valid.
- Alarm, evaluated on each window close:
  - If the new level > thresh: over_cnt increments, saturating at CONSEC. alarm <= 1 when over_cnt reaches CONSEC.
  - Otherwise: over_cnt <= 0 and alarm <= 0.
  - Comparison is strictly greater-than.
- thresh may change at any time; only its value at the window-close edge matters.
- reset asserted mid-window or mid-WARMUP: everything returns to reset values immediately (asynchronously). WARMUP restarts on release.
- level, peak and alarm hold their value between window closes.

Optional Feature:
- Macro: POWERLINE_RESIDUAL_PEAK_EN.
- Defined: a running max of |y_in| is tracked over ACCUM samples. At window close, peak <= max(running, |y_in| of the last sample) and the running max clears.
- Undefined: no peak logic is built and peak is tied to 0.

Decomposition:
- Package powerline_residual_pkg holds:
  - the state enum {WARMUP, ACCUM}
  - a function giving the saturation constant 2^(WL-1)-1 for a given WL
  - default parameter constants
- One sub-module, residual_abs_sat: purely combinational saturating absolute value, WL in, WL-1 out. It is shared by the accumulate and peak paths.

Test Plan:
- Settle and level, LOG2_WIN=4, SETTLE=2, y_valid=1 continuously, y_in=1000:
  - settling falls after 2 samples;
  - level=1000 with level_valid one cycle after the 18th sample edge;
  - level_valid repeats every 16 samples.
- Alternating ±3192516 (±779.4229 in Q16.12), 16-sample windows → level=3192516; peak=3192516 with POWERLINE_RESIDUAL_PEAK_EN.
- y_in=-2^27 for a full window → level=134217727, no wrap.
- y_valid toggling 1/0 every cycle, y_in=1000 → window close takes 32 clocks; level=1000.
- Alarm, CONSEC=2, thresh=500:
  - two windows at level 1000 → alarm rises at the second level_valid;
  - next window at level 500 → alarm=0.
- reset pulsed low after 10 samples of an ACCUM window → all outputs 0 and settling=1 immediately; after release, the first level_valid comes only after SETTLE+16 new samples.
